// File: rtl/hamming_encode_tx.sv
// Serial Hamming(7,4) transmitter: accepts a nibble by valid/ready, then sends
// a start bit and code bits c[0..6] = {d0,d1,d2,d3,p0,p1,p2}, one per clock.
module hamming_encode_tx #(
  parameter int unsigned GAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       err_en,
  input  logic [2:0] err_pos,
  output logic       tx,
  output logic       sent
);

  localparam int unsigned CW = 7;
  localparam int unsigned IW = 3;
  localparam int unsigned GW = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(CW - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP == 0) ? '0 : GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_GAP
  } state_t;

  state_t        r_state, w_state;
  logic [IW-1:0] r_idx,   w_idx;
  logic [GW-1:0] r_gcnt,  w_gcnt;
  logic [CW-1:0] r_sr,    w_sr;
  logic          r_tx,    w_tx;
  logic          r_sent,  w_sent;
  logic [CW-1:0] w_code;
  logic          w_accept;

  // Code word with optional single-bit fault; err_pos 7 shifts the mask out.
  always_comb begin
    w_code    = '0;
    w_code[0] = data_in[0];
    w_code[1] = data_in[1];
    w_code[2] = data_in[2];
    w_code[3] = data_in[3];
    w_code[4] = data_in[0] ^ data_in[1] ^ data_in[2];
    w_code[5] = data_in[0] ^ data_in[1] ^ data_in[3];
    w_code[6] = data_in[0] ^ data_in[2] ^ data_in[3];
    if (err_en) begin
      w_code = w_code ^ (CW'(1) << err_pos);
    end
  end

  always_comb begin
    ready_out = 1'b0;
    case (r_state)
      S_IDLE:  ready_out = 1'b1;
      S_BIT:   ready_out = (r_idx == LAST_IDX) && (GAP == 0);
      S_GAP:   ready_out = (r_gcnt == '0);
      default: ready_out = 1'b0;
    endcase
  end

  assign w_accept = valid_in && ready_out;

  // Next state; tx/sent are computed here for the following cycle.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_gcnt  = r_gcnt;
    w_sr    = r_sr;
    w_tx    = 1'b0;
    w_sent  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state = S_IDLE;
      end
      S_START: begin
        w_state = S_BIT;
        w_idx   = '0;
        w_tx    = r_sr[0];
        w_sr    = r_sr >> 1;
      end
      S_BIT: begin
        if (r_idx != LAST_IDX) begin
          w_idx  = r_idx + IW'(1);
          w_tx   = r_sr[0];
          w_sr   = r_sr >> 1;
          w_sent = (r_idx == LAST_IDX - IW'(1));
        end else if (GAP == 0) begin
          w_state = S_IDLE;
        end else begin
          w_state = S_GAP;
          w_gcnt  = GAP_LAST;
        end
      end
      S_GAP: begin
        if (r_gcnt == '0) begin
          w_state = S_IDLE;
        end else begin
          w_gcnt = r_gcnt - GW'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    // Accept overrides whatever the ready state would have done next.
    if (w_accept) begin
      w_state = S_START;
      w_sr    = w_code;
      w_tx    = 1'b1;
      w_sent  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_gcnt  <= '0;
      r_sr    <= '0;
      r_tx    <= 1'b0;
      r_sent  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_gcnt  <= w_gcnt;
      r_sr    <= w_sr;
      r_tx    <= w_tx;
      r_sent  <= w_sent;
    end
  end

  assign tx   = r_tx;
  assign sent = r_sent;

endmodule
